mvu_pe_popcount_acc: RTL and testbench
======================================

# mvu_pe_popcount_acc

Pipelined SIMD reduction and accumulation unit for one processing element of the Matrix-Vector-Multiplication Unit. Each valid beat, it sums SIMD lane products through an adder tree. It then accumulates SF consecutive beats, one synapse fold, into a single output word. In binary mode it applies the bipolar (XNOR-popcount) correction. It replaces the purely combinational lane adder: registered stages, fold counting, valid signalling and the bipolar mode are all new.

## Interface

Parameters:

- SIMD, 2: number of lanes per beat (≥1).
- TI, 1: lane input width, unsigned.
- TO, 16: accumulator/output width.
- SF, 4: beats per fold (≥1).
- BIPOLAR, 0: 1 means the output is 2·count − SIMD·SF, signed; legal only with TI=1.

Ports:

- aclk, input, 1: clock. Reset is asynchronous and active-low; the reset port is named aresetn.
- aresetn, input, 1: asynchronous active-low reset.
- in_v, input, 1: lane data valid this cycle.
- in_simd, input, [TI-1:0] × SIMD (unpacked [0:SIMD-1]): lane values.
- out_v, output, 1: single-cycle pulse; out_acc holds a finished fold.
- out_acc, output, TO: fold result.
- busy, output, 1: a fold is partially accumulated.

## Operation

- The tree sum is the unsigned sum of SIMD lanes. Its natural width is TI+$clog2(SIMD), and it is zero-extended to TO.
- Stage 1 registers the tree sum as sum_q, plus a valid bit v1, on every in_v.
- Stage 2 has two states, held in the fold counter sf_cnt (0..SF-1):
  - IDLE (sf_cnt=0): on v1, acc ← sum_q.
  - ACC (sf_cnt>0): on v1, acc ← acc + sum_q.
  - On v1, sf_cnt increments and wraps to 0 after SF-1.
  - If SF=1, every beat completes a fold.
- Completion is the v1 with sf_cnt=SF-1:
  - out_acc ← final, where final = (IDLE ? 0 : acc) + sum_q.
  - out_v ← 1 for one cycle.
  - The FSM returns to IDLE.
  - out_acc holds its value until the next completion.
- BIPOLAR=1: out_acc ← (final<<1) − SIMD·SF, computed in TO bits two's complement.
- Arithmetic: all adds are modulo 2^TO with no saturation or overflow flag. Sizing TO is the integrator's duty.
- Gaps: cycles with in_v=0 neither advance nor disturb the fold. Arbitrary idle gaps between beats are legal.
- Back-to-back folds: the first beat of the next fold may be in the same cycle as the completion beat of the previous one, so there is no bubble.
- No backpressure: the consumer must accept out_v whenever it is asserted.
- busy = (sf_cnt≠0).

## Timing

- Reset (aresetn=0, asynchronous) clears sum_q, v1, acc, sf_cnt, out_acc and out_v to 0, so busy=0.
- A partial fold in progress at reset is discarded. The first valid beat after release starts a new fold.
- Latency: out_v rises 2 clocks after the aclk edge that samples the fold's last in_v=1 beat. Inputs are sampled at edge t, out_v is high after edge t+2.
- Throughput: one beat per cycle; one result per SF valid beats.
- An in_v beat during the same cycle out_v is high is accepted normally.

## Structure

- Shared package mvau_defn:
  - A localparam helper computing the tree width, TI+$clog2(SIMD).
  - A typedef for the fold-counter FSM state enum (IDLE, ACC).
- Sub-module mvu_pe_addtree: parametrised (SIMD, TI, TO) combinational balanced adder tree, instantiated once for stage 1.
- The top level holds the stage registers, the fold counter/FSM and the bipolar correction.

## Test plan

1. Reset, with SIMD=4, TI=1, TO=8, SF=3:
   - Assert aresetn=0 with random inputs → out_v=0, out_acc=0x00, busy=0.
2. Unsigned accumulation:
   - Beats 4'b1111, 4'b1010, 4'b0001 on consecutive cycles → out_acc=7, with out_v one cycle high 2 clocks after the third beat.
   - busy is 1 after beat 1 and 0 after beat 3.
3. Gapped input:
   - Same three beats separated by 0, 3 and 5 idle cycles → out_acc=7, with one out_v pulse at the same relative latency.
4. Back-to-back folds:
   - Six continuous beats: first fold as in test 2, second fold 1111 ×3 → out_acc=7, then 12, with out_v pulses exactly 3 cycles apart.
5. Bipolar mode, BIPOLAR=1:
   - Fold of all ones → 2·12−12 = 12 (0x0C).
   - Fold of all zeros → −12 (0xF4).
   - Beats 1111, 0000, 1100 → 2·6−12 = 0.
6. Reset mid-fold and wrap-around:
   - Two beats of 1111, pulse aresetn low for 1 cycle, then three beats of 1111 → out_acc=12, and no output from the discarded fold.
   - With TI=4, SIMD=4, TO=4: three beats of all 15s → 180 mod 16 = 4.

Source files
------------

// File: rtl/mvu_pe_popcount_acc_pkg.sv
// Shared definitions for the MVU processing-element reduction datapath.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package mvau_defn;

  // Fold-counter state: IDLE when no beat of the current fold has been
  // absorbed yet, ACC once at least one partial sum sits in the accumulator.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } fold_state_t;

  // Natural width of the unsigned lane sum: one lane widened by the tree depth.
  function automatic int tree_width(input int simd, input int ti);
    return ti + $clog2(simd);
  endfunction

endpackage

// File: rtl/mvu_pe_popcount_acc_if.sv
// Beat input / fold result bundle between a lane source and one PE reducer.
// Latency: n/a (wiring only).
// Backpressure: none; the sink of out_v must accept every pulse.
interface mvu_pe_popcount_acc_if #(
  parameter int SIMD = 2,
  parameter int TI   = 1,
  parameter int TO   = 16
);

  logic          in_v;
  logic [TI-1:0] in_simd [0:SIMD-1];
  logic          out_v;
  logic [TO-1:0] out_acc;
  logic          busy;

  // Lane source side: drives beats, observes results.
  modport master (
    output in_v,
    output in_simd,
    input  out_v,
    input  out_acc,
    input  busy
  );

  // Reducer side: consumes beats, produces results.
  modport slave (
    input  in_v,
    input  in_simd,
    output out_v,
    output out_acc,
    output busy
  );

endinterface

// File: rtl/mvu_pe_popcount_acc_addtree.sv
// Balanced combinational adder tree summing SIMD unsigned lanes, zero-extended to TO.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module mvu_pe_addtree
  import mvau_defn::*;
#(
  parameter int SIMD = 2,
  parameter int TI   = 1,
  parameter int TO   = 16
) (
  input  logic [TI-1:0] i_lanes [0:SIMD-1],
  output logic [TO-1:0] o_sum
);

  // Every node carries the full tree width so no level can overflow.
  localparam int SW = tree_width(SIMD, TI);
  localparam int LV = $clog2(SIMD);
  localparam int NP = 1 << LV;

  // Heap layout: node 0 is the root, leaves live at NP-1 .. 2*NP-2.
  logic [SW-1:0] w_node [0:2*NP-2];

  genvar j;
  genvar n;

  generate
    // Leaves: real lanes, padded with zeros up to the next power of two.
    for (j = 0; j < NP; j++) begin : g_leaf
      if (j < SIMD) begin : g_lane
        assign w_node[NP-1+j] = SW'(i_lanes[j]);
      end else begin : g_pad
        assign w_node[NP-1+j] = '0;
      end
    end

    // Internal nodes: pairwise sums of the two children.
    for (n = 0; n < NP-1; n++) begin : g_node
      assign w_node[n] = w_node[2*n+1] + w_node[2*n+2];
    end
  endgenerate

  assign o_sum = TO'(w_node[0]);

endmodule

// File: rtl/mvu_pe_popcount_acc.sv
// SIMD lane reduction plus synapse-fold accumulation for one MVU processing element.
// Latency: out_v rises 2 clocks after the edge sampling the fold's last beat; 1 beat/cycle.
// Backpressure: none; out_v is a one-cycle pulse the consumer must take.
module mvu_pe_popcount_acc
  import mvau_defn::*;
#(
  parameter int SIMD    = 2,
  parameter int TI      = 1,
  parameter int TO      = 16,
  parameter int SF      = 4,
  parameter int BIPOLAR = 0
) (
  input logic                  aclk,
  input logic                  aresetn,
  mvu_pe_popcount_acc_if.slave bus
);

  localparam int            CW   = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CW-1:0] LAST = CW'(SF - 1);
  // Bipolar offset: every lane contributes -1 for a 0 and +1 for a 1.
  localparam logic [TO-1:0] BIAS = TO'(SIMD * SF);

  // Input capture keeps the tree off the raw input path.
  logic          r_in_v;
  logic [TI-1:0] r_lanes [0:SIMD-1];

  // Stage 1: registered tree sum.
  logic          r_v1;
  logic [TO-1:0] r_sum_q;
  logic [TO-1:0] w_tree;

  // Stage 2: fold accumulator and result.
  logic [CW-1:0] r_sf_cnt;
  logic [TO-1:0] r_acc;
  logic [TO-1:0] r_out_acc;
  logic          r_out_v;

  fold_state_t   w_state;
  logic          w_last;
  logic [TO-1:0] w_final;
  logic [TO-1:0] w_result;

  // Register the incoming beat; lanes only move on a valid beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_in_v <= 1'b0;
      for (int j = 0; j < SIMD; j++) begin
        r_lanes[j] <= '0;
      end
    end else begin
      r_in_v <= bus.in_v;
      if (bus.in_v) begin
        for (int j = 0; j < SIMD; j++) begin
          r_lanes[j] <= bus.in_simd[j];
        end
      end
    end
  end

  mvu_pe_addtree #(
    .SIMD (SIMD),
    .TI   (TI),
    .TO   (TO)
  ) u_addtree (
    .i_lanes (r_lanes),
    .o_sum   (w_tree)
  );

  // Stage 1: capture the lane sum alongside its valid bit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v1    <= 1'b0;
      r_sum_q <= '0;
    end else begin
      r_v1 <= r_in_v;
      if (r_in_v) begin
        r_sum_q <= w_tree;
      end
    end
  end

  // The fold state is implied by the counter: zero means nothing absorbed yet.
  assign w_state  = (r_sf_cnt == '0) ? IDLE : ACC;
  assign w_last   = (r_sf_cnt == LAST);
  // In IDLE the stale accumulator is ignored, so a new fold needs no clear cycle.
  assign w_final  = ((w_state == IDLE) ? '0 : r_acc) + r_sum_q;
  assign w_result = (BIPOLAR != 0) ? ((w_final << 1) - BIAS) : w_final;

  // Stage 2: fold counter, accumulation and registered result with valid pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sf_cnt  <= '0;
      r_acc     <= '0;
      r_out_acc <= '0;
      r_out_v   <= 1'b0;
    end else begin
      r_out_v <= 1'b0;
      if (r_v1) begin
        if (w_last) begin
          r_sf_cnt  <= '0;
          r_out_acc <= w_result;
          r_out_v   <= 1'b1;
        end else begin
          r_sf_cnt <= r_sf_cnt + CW'(1);
          r_acc    <= w_final;
        end
      end
    end
  end

  assign bus.out_v   = r_out_v;
  assign bus.out_acc = r_out_acc;
  assign bus.busy    = (r_sf_cnt != '0);

endmodule

// File: tb/tb_mvu_pe_popcount_acc.sv
// Bench for mvu_pe_popcount_acc: three instances (unsigned, bipolar, wrapping) share one beat stream.
// Latency: expected results are scheduled 2 edges after the completing beat is sampled.
// Backpressure: none; every out_v pulse is recorded and compared.
module tb_mvu_pe_popcount_acc;

  localparam int NI   = 3;
  localparam int MAXC = 4096;
  localparam int SFV  = 3;
  localparam int NL   = 4;

  int TOW [NI] = '{8, 8, 4};
  int BIP [NI] = '{0, 1, 0};

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;

  always #5 aclk = ~aclk;

  mvu_pe_popcount_acc_if #(.SIMD(4), .TI(1), .TO(8)) if0 ();
  mvu_pe_popcount_acc_if #(.SIMD(4), .TI(1), .TO(8)) if1 ();
  mvu_pe_popcount_acc_if #(.SIMD(4), .TI(4), .TO(4)) if2 ();

  mvu_pe_popcount_acc #(.SIMD(4), .TI(1), .TO(8), .SF(3), .BIPOLAR(0)) u_uni (
    .aclk (aclk), .aresetn (aresetn), .bus (if0.slave));
  mvu_pe_popcount_acc #(.SIMD(4), .TI(1), .TO(8), .SF(3), .BIPOLAR(1)) u_bip (
    .aclk (aclk), .aresetn (aresetn), .bus (if1.slave));
  mvu_pe_popcount_acc #(.SIMD(4), .TI(4), .TO(4), .SF(3), .BIPOLAR(0)) u_wrap (
    .aclk (aclk), .aresetn (aresetn), .bus (if2.slave));

  // Observed outputs, widened so all instances can be indexed alike.
  logic ov [NI];
  logic ob [NI];
  int   oacc [NI];
  assign ov[0]   = if0.out_v;
  assign ov[1]   = if1.out_v;
  assign ov[2]   = if2.out_v;
  assign ob[0]   = if0.busy;
  assign ob[1]   = if1.busy;
  assign ob[2]   = if2.busy;
  assign oacc[0] = {24'd0, if0.out_acc};
  assign oacc[1] = {24'd0, if1.out_acc};
  assign oacc[2] = {28'd0, if2.out_acc};

  // Stimulus as applied to the DUTs.
  logic       stim_v;
  logic [3:0] stim_b;
  logic [3:0] stim_w [0:NL-1];

  // Reference model state.
  int  cyc = 0;
  bit  chk_en = 1'b0;
  bit  pend_v   [NI][MAXC];
  int  pend_acc [NI][MAXC];
  bit  busy_at  [NI][MAXC];
  int  cnt  [NI];
  int  fsum [NI];
  int  hold [NI];
  int  lsum;
  int  res;

  typedef struct {
    int inst;
    int c;
    int v;
  } pulse_t;
  pulse_t pq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Model: fold = SF accepted beats; result appears 2 edges after the last one.
  always @(posedge aclk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      pend_v[i][cyc+2] = 1'b0;
      if (!aresetn) begin
        cnt[i]  = 0;
        fsum[i] = 0;
      end else if (stim_v) begin
        lsum = 0;
        for (int j = 0; j < NL; j++) begin
          lsum += (i == 2) ? int'(stim_w[j]) : int'(stim_b[j]);
        end
        fsum[i] += lsum;
        cnt[i]++;
        if (cnt[i] == SFV) begin
          res = (BIP[i] != 0) ? (2 * fsum[i] - NL * SFV) : fsum[i];
          pend_acc[i][cyc+2] = res & ((1 << TOW[i]) - 1);
          pend_v[i][cyc+2]   = 1'b1;
          cnt[i]  = 0;
          fsum[i] = 0;
        end
      end
      busy_at[i][cyc+2] = (cnt[i] != 0);
    end
  end

  // Reset discards every partial fold and any result still in flight.
  always @(negedge aresetn) begin
    for (int i = 0; i < NI; i++) begin
      cnt[i]  = 0;
      fsum[i] = 0;
      hold[i] = 0;
      for (int d = 1; d <= 3; d++) begin
        pend_v[i][cyc+d]  = 1'b0;
        busy_at[i][cyc+d] = 1'b0;
      end
    end
  end

  // Compare every output of every instance on each falling edge.
  always @(negedge aclk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        bit ev;
        bit eb;
        ev = aresetn && pend_v[i][cyc];
        eb = aresetn && busy_at[i][cyc];
        if (!aresetn) hold[i] = 0;
        else if (ev) hold[i] = pend_acc[i][cyc];
        chk($sformatf("i%0d out_v @%0d", i, cyc), int'(ov[i]), int'(ev));
        chk($sformatf("i%0d out_acc @%0d", i, cyc), oacc[i], hold[i]);
        chk($sformatf("i%0d busy @%0d", i, cyc), int'(ob[i]), int'(eb));
        if (ov[i]) pq.push_back('{inst: i, c: cyc, v: oacc[i]});
      end
    end
  end

  task automatic apply(input logic v, input logic [3:0] b, input logic [15:0] w);
    stim_v = v;
    stim_b = b;
    for (int j = 0; j < NL; j++) stim_w[j] = w[4*j +: 4];
    if0.in_v = v;
    if1.in_v = v;
    if2.in_v = v;
    for (int j = 0; j < NL; j++) begin
      if0.in_simd[j] = b[j];
      if1.in_simd[j] = b[j];
      if2.in_simd[j] = w[4*j +: 4];
    end
  endtask

  task automatic beat(input logic v, input logic [3:0] b, input logic [15:0] w);
    @(posedge aclk);
    #1;
    apply(v, b, w);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(1'b0, 4'($urandom), 16'($urandom));
  endtask

  task automatic pulse_rst();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    apply(1'b0, 4'($urandom), 16'($urandom));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic chk_npulse(input string nm, input int inst, input int n);
    int seen = 0;
    foreach (pq[k]) if (pq[k].inst == inst) seen++;
    chk(nm, seen, n);
  endtask

  task automatic chk_pulse(input string nm, input int inst, input int k, input int ec, input int ev);
    int seen = 0;
    int c = -1;
    int v = -1;
    foreach (pq[m]) begin
      if (pq[m].inst == inst) begin
        if (seen == k) begin
          c = pq[m].c;
          v = pq[m].v;
        end
        seen++;
      end
    end
    chk({nm, " cycle"}, c, ec);
    chk({nm, " value"}, v, ev);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int ta;
    int tb;
    int tc;

    apply(1'b0, 4'd0, 16'd0);
    #1;
    aresetn = 1'b0;
    #1;
    chk_en = 1'b1;

    // Test 1: reset with random inputs.
    for (int k = 0; k < 4; k++) beat(1'($urandom), 4'($urandom), 16'($urandom));
    chk("t1 reset out_v", int'(ov[0]), 0);
    chk("t1 reset out_acc", oacc[0], 0);
    chk("t1 reset busy", int'(ob[0]), 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    apply(1'b0, 4'd0, 16'd0);
    idle(2);

    // Test 2: unsigned accumulation 4 + 2 + 1.
    pq.delete();
    beat(1'b1, 4'b1111, 16'($urandom));
    beat(1'b1, 4'b1010, 16'($urandom));
    beat(1'b1, 4'b0001, 16'($urandom));
    ta = cyc + 1;
    idle(6);
    chk_npulse("t2 pulses", 0, 1);
    chk_pulse("t2 fold", 0, 0, ta + 2, 7);

    // Test 3: same beats with idle gaps.
    pq.delete();
    beat(1'b1, 4'b1111, 16'($urandom));
    idle(3);
    beat(1'b1, 4'b1010, 16'($urandom));
    idle(5);
    beat(1'b1, 4'b0001, 16'($urandom));
    ta = cyc + 1;
    idle(6);
    chk_npulse("t3 pulses", 0, 1);
    chk_pulse("t3 fold", 0, 0, ta + 2, 7);

    // Test 4: back-to-back folds.
    pq.delete();
    beat(1'b1, 4'b1111, 16'($urandom));
    beat(1'b1, 4'b1010, 16'($urandom));
    beat(1'b1, 4'b0001, 16'($urandom));
    ta = cyc + 1;
    for (int k = 0; k < 3; k++) beat(1'b1, 4'b1111, 16'($urandom));
    tb = cyc + 1;
    idle(6);
    chk_npulse("t4 pulses", 0, 2);
    chk_pulse("t4 fold0", 0, 0, ta + 2, 7);
    chk_pulse("t4 fold1", 0, 1, ta + 5, 12);
    chk("t4 beat spacing", tb - ta, 3);

    // Test 5: bipolar correction on instance 1.
    pq.delete();
    for (int k = 0; k < 3; k++) beat(1'b1, 4'b1111, 16'($urandom));
    ta = cyc + 1;
    for (int k = 0; k < 3; k++) beat(1'b1, 4'b0000, 16'($urandom));
    tb = cyc + 1;
    beat(1'b1, 4'b1111, 16'($urandom));
    beat(1'b1, 4'b0000, 16'($urandom));
    beat(1'b1, 4'b1100, 16'($urandom));
    tc = cyc + 1;
    idle(6);
    chk_npulse("t5 pulses", 1, 3);
    chk_pulse("t5 ones", 1, 0, ta + 2, 12);
    chk_pulse("t5 zeros", 1, 1, tb + 2, 244);
    chk_pulse("t5 mixed", 1, 2, tc + 2, 0);

    // Test 6: reset mid-fold, then modulo wrap on instance 2.
    pq.delete();
    beat(1'b1, 4'b1111, 16'($urandom));
    beat(1'b1, 4'b1111, 16'($urandom));
    pulse_rst();
    for (int k = 0; k < 3; k++) beat(1'b1, 4'b1111, 16'hFFFF);
    ta = cyc + 1;
    idle(6);
    chk_npulse("t6 pulses", 0, 1);
    chk_pulse("t6 fold", 0, 0, ta + 2, 12);
    chk_pulse("t6 wrap", 2, 0, ta + 2, 4);

    // Random phase: mixed valid density with occasional resets.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(99) == 0) pulse_rst();
      else beat(1'($urandom_range(99) < 70), 4'($urandom), 16'($urandom));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
